// File: rtl/mem_bus_arb_pkg.sv
// Shared types and constants for the memory bus arbiter and its helpers.
package mem_bus_arb_pkg;

  // Arbiter FSM: IDLE arbitrates and issues, WAIT holds for the single response.
  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_t;

  // Master indices: fetch is M0, load/store data is M1.
  localparam logic MST_FETCH = 1'b0;
  localparam logic MST_DATA  = 1'b1;

  // Read data returned to the owner when the slave never answers.
  localparam logic [31:0] DEF_ERR_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_watchdog.sv
// Clear/enable counter with a terminal-count flag at TIMEOUT_CYCLES-1.
// Used to bound how long a bus master waits for a slave response.
module bus_watchdog #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Clear has priority over counting so a new transaction always starts at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
  assign o_tc    = (r_count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master request/grant arbiter in front of the memory/MMIO slave port.
// M0 = instruction fetch, M1 = load/store. One transaction outstanding at a time.
//
// Handshake: a master holds req with stable fields until its one-cycle gnt.
// The slave accepts when s_req and s_ready are both high in the same cycle and
// later returns exactly one s_rvalid; that pulse is forwarded combinationally
// to the owning master. A watchdog turns a missing response into an error
// response (rerr=1, rdata=ERR_RDATA) and sets the sticky bus_err flag.
module mem_bus_arbiter
  import mem_bus_arb_pkg::*;
#(
  parameter int          STARVE_LIMIT   = 4,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_RDATA      = DEF_ERR_RDATA,
  parameter int          SC_W           = $clog2(STARVE_LIMIT + 1),
  parameter int          WD_W           = $clog2(TIMEOUT_CYCLES) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m0_req,
  input  logic            m0_we,
  input  logic [31:0]     m0_addr,
  input  logic [31:0]     m0_wdata,
  input  logic [2:0]      m0_fn3,
  output logic            m0_gnt,
  output logic            m0_rvalid,
  output logic [31:0]     m0_rdata,
  output logic            m0_rerr,
  input  logic            m1_req,
  input  logic            m1_we,
  input  logic [31:0]     m1_addr,
  input  logic [31:0]     m1_wdata,
  input  logic [2:0]      m1_fn3,
  output logic            m1_gnt,
  output logic            m1_rvalid,
  output logic [31:0]     m1_rdata,
  output logic            m1_rerr,
  output logic            s_req,
  output logic            s_we,
  output logic [31:0]     s_addr,
  output logic [31:0]     s_wdata,
  output logic [2:0]      s_fn3,
  input  logic            s_ready,
  input  logic            s_rvalid,
  input  logic [31:0]     s_rdata,
  output logic            bus_err,
  output logic            dbg_state,
  output logic            dbg_owner,
  output logic [SC_W-1:0] dbg_starve_cnt,
  output logic [WD_W-1:0] dbg_wdog
);

  arb_state_t      r_state;
  logic            r_owner;
  logic [SC_W-1:0] r_starve_cnt;
  logic            r_bus_err;

  logic            w_idle;
  logic            w_wait;
  logic            w_forced;
  logic            w_win;
  logic            w_any;
  logic            w_accept;
  logic            w_resp;
  logic            w_tout;
  logic            w_done;
  logic            w_wd_tc;
  logic [WD_W-1:0] w_wd_count;

  // Outputs are qualified by rst_n so everything reads 0 the moment reset asserts.
  assign w_idle   = rst_n && (r_state == IDLE);
  assign w_wait   = rst_n && (r_state == WAIT);
  // Fetch is forced to win only when it is actually waiting and has been starved.
  assign w_forced = m0_req && (r_starve_cnt == SC_W'(STARVE_LIMIT));
  assign w_win    = (m1_req && !w_forced) ? MST_DATA : MST_FETCH;
  assign w_any    = w_idle && (m0_req || m1_req);
  assign w_accept = w_any && s_ready;
  // A response in the terminal watchdog cycle beats the timeout.
  assign w_resp   = w_wait && s_rvalid;
  assign w_tout   = w_wait && !s_rvalid && w_wd_tc;
  assign w_done   = w_resp || w_tout;

  // Slave request path: driven from the current winner, all zero when idle.
  always_comb begin
    s_req   = 1'b0;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_fn3   = '0;
    if (w_any) begin
      s_req = 1'b1;
      if (w_win == MST_DATA) begin
        s_we    = m1_we;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_fn3   = m1_fn3;
      end else begin
        s_we    = m0_we;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_fn3   = m0_fn3;
      end
    end
  end

  assign m0_gnt = w_accept && (w_win == MST_FETCH);
  assign m1_gnt = w_accept && (w_win == MST_DATA);

  // Response path: route the slave response or the timeout error to the owner only.
  always_comb begin
    m0_rvalid = 1'b0;
    m0_rdata  = '0;
    m0_rerr   = 1'b0;
    m1_rvalid = 1'b0;
    m1_rdata  = '0;
    m1_rerr   = 1'b0;
    if (w_done) begin
      if (r_owner == MST_DATA) begin
        m1_rvalid = 1'b1;
        m1_rdata  = w_resp ? s_rdata : ERR_RDATA;
        m1_rerr   = w_tout;
      end else begin
        m0_rvalid = 1'b1;
        m0_rdata  = w_resp ? s_rdata : ERR_RDATA;
        m0_rerr   = w_tout;
      end
    end
  end

  // FSM: IDLE -> WAIT on acceptance, WAIT -> IDLE on response or timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) r_state <= WAIT;
        WAIT:    if (w_done)   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Owner latch: remembers who gets the response of the accepted transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_owner <= MST_FETCH;
    end else if (w_accept) begin
      r_owner <= w_win;
    end
  end

  // Starve counter: counts data grants that beat a waiting fetch, saturating.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve_cnt <= '0;
    end else if (w_accept) begin
      if (w_win == MST_FETCH) begin
        r_starve_cnt <= '0;
      end else if (m0_req && (r_starve_cnt != SC_W'(STARVE_LIMIT))) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end
    end
  end

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
    end else if (w_tout) begin
      r_bus_err <= 1'b1;
    end
  end

  bus_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .CNT_W          (WD_W)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (w_accept),
    .i_en    (w_wait),
    .o_count (w_wd_count),
    .o_tc    (w_wd_tc)
  );

  assign bus_err        = r_bus_err;
  assign dbg_state      = r_state;
  assign dbg_owner      = r_owner;
  assign dbg_starve_cnt = r_starve_cnt;
  assign dbg_wdog       = w_wd_count;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + light random bench for mem_bus_arbiter with a response scoreboard.
module tb_mem_bus_arbiter;

  localparam int          SL   = 4;
  localparam int          TO   = 8;
  localparam int          SC_W = $clog2(SL + 1);
  localparam int          WD_W = $clog2(TO) + 1;
  localparam logic [31:0] ERR  = 32'hDEADBEEF;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic            m0_req, m0_we, m1_req, m1_we;
  logic [31:0]     m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [2:0]      m0_fn3, m1_fn3;
  logic            m0_gnt, m0_rvalid, m0_rerr, m1_gnt, m1_rvalid, m1_rerr;
  logic [31:0]     m0_rdata, m1_rdata;
  logic            s_req, s_we, s_ready;
  logic [31:0]     s_addr, s_wdata;
  logic [2:0]      s_fn3;
  logic            s_rvalid = 1'b0;
  logic [31:0]     s_rdata  = 32'h0;
  logic            bus_err, dbg_state, dbg_owner;
  logic [SC_W-1:0] dbg_starve_cnt;
  logic [WD_W-1:0] dbg_wdog;

  mem_bus_arbiter #(
    .STARVE_LIMIT   (SL),
    .TIMEOUT_CYCLES (TO),
    .ERR_RDATA      (ERR)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_fn3         (m0_fn3),
    .m0_gnt         (m0_gnt),
    .m0_rvalid      (m0_rvalid),
    .m0_rdata       (m0_rdata),
    .m0_rerr        (m0_rerr),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_fn3         (m1_fn3),
    .m1_gnt         (m1_gnt),
    .m1_rvalid      (m1_rvalid),
    .m1_rdata       (m1_rdata),
    .m1_rerr        (m1_rerr),
    .s_req          (s_req),
    .s_we           (s_we),
    .s_addr         (s_addr),
    .s_wdata        (s_wdata),
    .s_fn3          (s_fn3),
    .s_ready        (s_ready),
    .s_rvalid       (s_rvalid),
    .s_rdata        (s_rdata),
    .bus_err        (bus_err),
    .dbg_state      (dbg_state),
    .dbg_owner      (dbg_owner),
    .dbg_starve_cnt (dbg_starve_cnt),
    .dbg_wdog       (dbg_wdog)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_err    = 0;
  logic [33:0] exp_q[$];            // {master, rerr, rdata}
  int          slave_lat = 0;       // -1: slave never answers
  int          rsp_cd    = -1;
  logic [31:0] rsp_data  = 32'h0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((dbg_state !== 1'b0 || exp_q.size() != 0) && n < 40) begin
      next_cyc();
      n++;
    end
    chk({tag, "_drain"}, (n < 40), 1);
  endtask

  // ---------------- slave model ----------------
  always @(posedge clk) begin
    #2;
    if (rsp_cd == 0) begin
      s_rvalid = 1'b1;
      s_rdata  = rsp_data;
      rsp_cd   = -1;
    end else begin
      s_rvalid = 1'b0;
      s_rdata  = 32'h0;
      if (rsp_cd > 0) rsp_cd--;
    end
  end

  // ---------------- monitor: accept tracking and response scoreboard ----------------
  always @(negedge clk) begin : mon
    logic [33:0] e;
    if (rst_n) begin
      if (m0_rvalid || m1_rvalid) begin
        chk("dual_rvalid", m0_rvalid & m1_rvalid, 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_rvalid", m0_rvalid | m1_rvalid, 0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp", {m1_rvalid, (m1_rvalid ? m1_rerr : m0_rerr),
                      (m1_rvalid ? m1_rdata : m0_rdata)}, e);
        end
      end
      if (s_req && s_ready) rsp_cd = slave_lat;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic        exp_m;
    int          exp_sc[6];
    logic        mst;
    logic [31:0] data;
    exp_sc = '{1, 2, 3, 4, 0, 1};

    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_fn3 = 0;
    m1_req = 1; m1_we = 0; m1_addr = 32'h2000_0000; m1_wdata = 0; m1_fn3 = 0;
    s_ready = 1;

    // Reset state, with a request held during reset
    #3;
    chk("rst_s_req", s_req, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_s_addr", s_addr, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_state", dbg_state, 0);
    chk("rst_starve", dbg_starve_cnt, 0);
    next_cyc();
    next_cyc();
    m1_req = 0;
    rst_n  = 1;
    next_cyc();

    // Single read from fetch
    m0_req = 1; m0_addr = 32'h8000_0000; m0_fn3 = 3'b010;
    slave_lat = 1; rsp_data = 32'h0000_0013;
    at_neg();
    chk("rd_s_req", s_req, 1);
    chk("rd_s_addr", s_addr, 32'h8000_0000);
    chk("rd_s_fn3", s_fn3, 3'b010);
    chk("rd_m0_gnt", m0_gnt, 1);
    chk("rd_m1_gnt", m1_gnt, 0);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0013});
    next_cyc();
    m0_req = 0;
    at_neg();
    chk("rd_c1_s_req", s_req, 0);
    chk("rd_c1_state", dbg_state, 1);
    chk("rd_c1_rvalid", m0_rvalid, 0);
    next_cyc();
    at_neg();
    chk("rd_c2_rvalid", m0_rvalid, 1);
    chk("rd_c2_rdata", m0_rdata, 32'h0000_0013);
    next_cyc();
    at_neg();
    chk("rd_c3_state", dbg_state, 0);
    next_cyc();

    // Contention: M1,M1,M1,M1,M0,M1
    m0_req = 1; m0_addr = 32'h8000_0010;
    m1_req = 1; m1_addr = 32'h2000_0000; m1_we = 0;
    slave_lat = 0; rsp_data = 32'hC0FF_EE00;
    for (int i = 0; i < 6; i++) begin
      exp_m = (i == 4) ? 1'b0 : 1'b1;
      at_neg();
      chk("cont_m1_gnt", m1_gnt, exp_m);
      chk("cont_m0_gnt", m0_gnt, !exp_m);
      exp_q.push_back({exp_m, 1'b0, rsp_data});
      next_cyc();
      if (i == 5) begin
        m0_req = 0;
        m1_req = 0;
      end
      at_neg();
      chk("cont_starve", dbg_starve_cnt, exp_sc[i]);
      next_cyc();
    end
    wait_drain("cont");

    // Slave backpressure on an M1 write
    m1_req = 1; m1_we = 1; m1_addr = 32'h1000_0008; m1_wdata = 32'h41; m1_fn3 = 3'b010;
    s_ready = 0; slave_lat = 2; rsp_data = 32'h0;
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("bp_s_req", s_req, 1);
      chk("bp_s_addr", s_addr, 32'h1000_0008);
      chk("bp_s_wdata", s_wdata, 32'h41);
      chk("bp_s_we", s_we, 1);
      chk("bp_no_gnt", m1_gnt, 0);
      next_cyc();
    end
    s_ready = 1;
    at_neg();
    chk("bp_gnt", m1_gnt, 1);
    exp_q.push_back({1'b1, 1'b0, 32'h0});
    next_cyc();
    m1_req = 0; m1_we = 0;
    wait_drain("bp");
    chk("bp_bus_err", bus_err, 0);

    // Timeout on a fetch read
    m0_req = 1; m0_addr = 32'h2000_0004; slave_lat = -1;
    exp_q.push_back({1'b0, 1'b1, ERR});
    at_neg();
    chk("to_gnt", m0_gnt, 1);
    next_cyc();
    m0_req = 0;
    for (int k = 1; k < TO; k++) begin
      at_neg();
      chk("to_quiet", m0_rvalid, 0);
      next_cyc();
    end
    at_neg();
    chk("to_rvalid", m0_rvalid, 1);
    chk("to_rerr", m0_rerr, 1);
    chk("to_rdata", m0_rdata, ERR);
    next_cyc();
    at_neg();
    chk("to_bus_err", bus_err, 1);
    chk("to_state", dbg_state, 0);
    next_cyc();
    rsp_data = 32'h55;
    rsp_cd   = 0;
    at_neg();
    chk("stray_m0", m0_rvalid, 0);
    chk("stray_m1", m1_rvalid, 0);
    next_cyc();

    // Response in the terminal watchdog cycle wins over the timeout
    m1_req = 1; m1_we = 0; m1_addr = 32'h2000_0008;
    slave_lat = TO - 1; rsp_data = 32'hAAAA_5555;
    exp_q.push_back({1'b1, 1'b0, 32'hAAAA_5555});
    at_neg();
    chk("tie_gnt", m1_gnt, 1);
    next_cyc();
    m1_req = 0;
    for (int k = 1; k < TO; k++) begin
      at_neg();
      chk("tie_quiet", m1_rvalid, 0);
      next_cyc();
    end
    at_neg();
    chk("tie_wdog", dbg_wdog, TO - 1);
    chk("tie_rvalid", m1_rvalid, 1);
    chk("tie_rerr", m1_rerr, 0);
    chk("tie_rdata", m1_rdata, 32'hAAAA_5555);
    next_cyc();
    at_neg();
    chk("tie_bus_err", bus_err, 1);
    chk("tie_state", dbg_state, 0);
    next_cyc();

    // Reset in the middle of WAIT, fetch still requesting
    m0_req = 1; m0_addr = 32'h8000_0020;
    m1_req = 1; m1_addr = 32'h2000_0010;
    slave_lat = -1;
    at_neg();
    chk("mr_gnt", m1_gnt, 1);
    next_cyc();
    m1_req = 0;
    at_neg();
    chk("mr_starve_pre", dbg_starve_cnt, 1);
    next_cyc();
    #2;
    rst_n = 0;
    #1;
    chk("mr_s_req", s_req, 0);
    chk("mr_m0_gnt", m0_gnt, 0);
    chk("mr_m1_rvalid", m1_rvalid, 0);
    chk("mr_bus_err", bus_err, 0);
    chk("mr_state", dbg_state, 0);
    chk("mr_starve", dbg_starve_cnt, 0);
    next_cyc();
    rst_n = 1;
    slave_lat = 0; rsp_data = 32'h77;
    at_neg();
    chk("mr_post_gnt", m0_gnt, 1);
    exp_q.push_back({1'b0, 1'b0, 32'h77});
    next_cyc();
    m0_req = 0;
    wait_drain("mr");

    // Short random phase: single requester, random slave latency and data
    for (int i = 0; i < 6; i++) begin
      mst  = 1'($urandom_range(0, 1));
      data = $urandom;
      slave_lat = $urandom_range(0, 3);
      rsp_data  = data;
      if (mst) begin
        m1_req = 1; m1_addr = $urandom;
      end else begin
        m0_req = 1; m0_addr = $urandom;
      end
      exp_q.push_back({mst, 1'b0, data});
      at_neg();
      chk("rnd_gnt", {m1_gnt, m0_gnt}, mst ? 2'b10 : 2'b01);
      next_cyc();
      m0_req = 0; m1_req = 0;
      wait_drain("rnd");
    end

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Run-time bound so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit exceeded");
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one memory/MMIO slave port (SRAM, UART, I2C behind the address decoder) between two requesters: instruction fetch (M0) and load/store data access (M1).
- Sits between the pipelined core and the address decoder. It replaces the fixed 4-phase time-slot sequencing with request/grant arbitration.
- One outstanding transaction at a time. Includes an anti-starvation counter for fetch and a response watchdog.

Parameters:
- STARVE_LIMIT, 4: consecutive contested data grants after which fetch is forced to win.
- TIMEOUT_CYCLES, 64: cycles in WAIT without s_rvalid before an error response is returned.
- ERR_RDATA, 32'hDEADBEEF: rdata returned on timeout.

Ports:
- clk  in  1  single clock; all state on posedge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- m0_req / m1_req  in  1  request. Held, with fields stable, until the matching gnt.
- m0_we / m1_we  in  1  write enable (m0_we is tied 0 by fetch but still honoured).
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_fn3 / m1_fn3  in  3  access size/sign (funct3 encoding).
- m0_gnt / m1_gnt  out  1  one-cycle accept pulse.
- m0_rvalid / m1_rvalid  out  1  one-cycle response pulse.
- m0_rdata / m1_rdata  out  32  response data; valid only with rvalid.
- m0_rerr / m1_rerr  out  1  qualifies rvalid; 1 means timeout.
- s_req  out  1  slave request.
- s_we  out  1  slave write enable.
- s_addr  out  32  slave address.
- s_wdata  out  32  slave write data.
- s_fn3  out  3  slave access size/sign.
- s_ready  in  1  slave accepts this cycle.
- s_rvalid  in  1  slave response (one per accepted request, reads and writes).
- s_rdata  in  32  slave read data.
- bus_err  out  1  sticky: set on any timeout, cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, starve_cnt=0, wdog=0, owner=M0.
  - All outputs are 0. Any in-flight transaction is dropped with no response.
- States: IDLE, WAIT.
- IDLE:
  - Winner selection: M1 if m1_req and not forced; M0 if m0_req and (not m1_req or starve_cnt==STARVE_LIMIT).
  - s_* is combinationally driven from the winner and s_req=1. With no request, s_req=0 and the other s_* fields are 0.
  - If s_ready is high the same cycle: pulse winner gnt, latch owner, clear wdog, go to WAIT.
  - If s_ready is low: no gnt, stay in IDLE, and re-evaluate the winner next cycle. A newly arrived M1 may preempt a not-yet-accepted M0 unless forced.
- Starve counter:
  - Updates only on a gnt.
  - M1 granted while m0_req=1: starve_cnt+1, saturating at STARVE_LIMIT.
  - M0 granted: starve_cnt=0.
  - M1 granted with m0_req=0: starve_cnt unchanged.
- WAIT:
  - s_req=0. wdog increments each cycle.
  - On s_rvalid: owner rvalid=1, rdata=s_rdata, rerr=0, combinational same-cycle pass-through. Next state IDLE.
  - Exactly one idle cycle separates transactions, so the minimum period is 2 cycles + slave latency.
  - Non-owner rvalid is always 0.
- Timeout: if wdog reaches TIMEOUT_CYCLES-1 with no s_rvalid:
  - owner rvalid=1, rerr=1, rdata=ERR_RDATA.
  - bus_err<=1; next state IDLE.
  - s_rvalid in the same cycle wins: normal response, no error.
- s_rvalid seen in IDLE (a late response to an abandoned transaction) is ignored and never forwarded.
- A master must not deassert req before gnt. Behaviour if it does is undefined; no checking is required.
- wdog width: $clog2(TIMEOUT_CYCLES)+1. starve_cnt width: $clog2(STARVE_LIMIT+1).

Decomposition:
- Package mem_bus_arb_pkg holds:
  - arb_state_t enum {IDLE, WAIT};
  - master index constants MST_FETCH=0, MST_DATA=1;
  - default ERR_RDATA.
- One sub-module: bus_watchdog, the clear/enable/terminal-count counter parameterised by TIMEOUT_CYCLES. It is also reused later for the UART/I2C MMIO paths.

Test Plan:
- Single read: m0_req, addr=32'h80000000, s_ready=1, slave rvalid 1 cycle later with 32'h00000013 -> m0_gnt in cycle 0, m0_rvalid+rdata=32'h00000013 in cycle 2, s_req=0 in cycle 1.
- Contention: m0_req and m1_req held continuously, s_ready=1, STARVE_LIMIT=4 -> grant order M1,M1,M1,M1,M0,M1… and starve_cnt returns to 0 after the M0 grant.
- Slave backpressure: m1 write addr=32'h10000008, wdata=32'h41, s_ready low 3 cycles -> s_req with fields stable 3 cycles, gnt on the 4th, m1_rvalid after s_rvalid, rerr=0.
- Timeout: TIMEOUT_CYCLES=8, s_rvalid never asserted -> owner rvalid=1, rerr=1, rdata=32'hDEADBEEF 8 cycles after gnt; bus_err stays 1; a later stray s_rvalid in IDLE produces no m*_rvalid.
- Timeout/response tie: s_rvalid in the terminal wdog cycle -> normal response, rerr=0, bus_err unchanged.
- Reset mid-WAIT: rst_n low asynchronously -> all outputs 0 immediately; after release state=IDLE, starve_cnt=0, no response for the dropped transaction.
